// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer
//   Loads a parallel pattern of programmable length and sends it one bit per
//   step strobe, MSB-first, on bit_out. The pattern can run once or repeat
//   continuously. A single-shot pattern ends with a one-cycle done pulse, and
//   abort cancels the pattern at any point.
//
// Ports
//   clk        rising-edge system clock
//   rst        asynchronous active-low reset
//   load       capture data_in/len (accepted only while ready=1)
//   data_in    pattern; data_in[len-1] is sent first
//   len        pattern length, legal range 1..WIDTH
//   repeat_en  restart the pattern after its last bit (sampled on that step)
//   step       advance strobe; one bit consumed per clock with step=1
//   abort      synchronous cancel, highest synchronous priority
//   bit_out    current serial bit
//   bit_valid  bit_out carries a pattern bit
//   ready      idle, load will be accepted
//   done       one-cycle pulse after a non-repeating pattern completes
//   err        one-cycle pulse on a load with an illegal len
module seq_bit_serializer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic [LEN_W-1:0] len,
   input  logic             repeat_en,
   input  logic             step,
   input  logic             abort,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             ready,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] saved_q, saved_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             bit_out_q, bit_out_d;
   logic             bit_valid_q, bit_valid_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] aligned;
   logic             len_ok;

   // The pattern is left-aligned so the bit on air is always shift_q[WIDTH-1];
   // data_in bits above len-1 fall off the top and are ignored.
   always_comb begin
      aligned = data_in << (WIDTH - 32'(len));
      len_ok  = (len != '0) && (len <= MAX_LEN);
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      saved_d     = saved_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      bit_out_d   = bit_out_q;
      bit_valid_d = bit_valid_q;
      ready_d     = ready_q;
      done_d      = 1'b0;
      err_d       = 1'b0;

      if (abort) begin
         state_d     = IDLE;
         bit_out_d   = 1'b0;
         bit_valid_d = 1'b0;
         ready_d     = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (load) begin
                  if (len_ok) begin
                     state_d     = SHIFT;
                     shift_d     = aligned;
                     saved_d     = aligned;
                     cnt_d       = len;
                     len_d       = len;
                     bit_out_d   = aligned[WIDTH-1];
                     bit_valid_d = 1'b1;
                     ready_d     = 1'b0;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (step) begin
                  if (cnt_q > LEN_W'(1)) begin
                     shift_d   = shift_q << 1;
                     cnt_d     = cnt_q - LEN_W'(1);
                     bit_out_d = shift_d[WIDTH-1];
                  end else if (repeat_en) begin
                     // Reload without a gap: bit_valid stays high.
                     shift_d   = saved_q;
                     cnt_d     = len_q;
                     bit_out_d = saved_q[WIDTH-1];
                  end else begin
                     state_d     = DONE;
                     bit_out_d   = 1'b0;
                     bit_valid_d = 1'b0;
                     done_d      = 1'b1;
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
               ready_d = 1'b1;
            end
            default: begin
               state_d     = IDLE;
               bit_out_d   = 1'b0;
               bit_valid_d = 1'b0;
               ready_d     = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         saved_q     <= '0;
         cnt_q       <= '0;
         len_q       <= '0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         saved_q     <= saved_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         bit_out_q   <= bit_out_d;
         bit_valid_q <= bit_valid_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign bit_out   = bit_out_q;
   assign bit_valid = bit_valid_q;
   assign ready     = ready_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
Upstream source for the serial sequence detectors. Loads a parallel pattern of programmable length and presents it one bit per step strobe, MSB-first, on a single-bit stream that drives a detector's seqIn. Supports single-shot or continuously repeating patterns, abort, and a done pulse, so detector stimulus can be driven from switches or control logic instead of a bench.

Parameters:
WIDTH, 8, maximum pattern length in bits
LEN_W, 4, width of len port; must satisfy 2^LEN_W > WIDTH

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset (0 = reset)
load  input  1  request to capture data_in/len; accepted only when ready=1
data_in  input  WIDTH  pattern; the len-bit pattern is data_in[len-1:0], first bit sent = data_in[len-1]
len  input  LEN_W  number of bits to send; legal range 1..WIDTH
repeat_en  input  1  1 = restart pattern after last bit; sampled on the last-bit step
step  input  1  advance strobe; one bit consumed per clock with step=1
abort  input  1  synchronous cancel, highest synchronous priority
bit_out  output  1  current serial bit (connects to detector seqIn)
bit_valid  output  1  bit_out is a pattern bit
ready  output  1  idle, can accept load
done  output  1  one-cycle pulse after a non-repeating pattern completes
err  output  1  one-cycle pulse on load with illegal len

Behaviour:
- Reset (rst=0, async): state IDLE; bit_out=0, bit_valid=0, ready=1, done=0, err=0; shift register, saved pattern, and bit counter cleared. Reset takes effect immediately mid-pattern; no done pulse.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE: ready=1, bit_valid=0, bit_out=0.
  - load=1, 1<=len<=WIDTH: capture data_in[len-1:0] into shift register and saved copy; counter=len. Next cycle: state SHIFT, bit_out=data_in[len-1], bit_valid=1, ready=0.
  - load=1, len=0 or len>WIDTH: err=1 for one cycle; remain IDLE; no capture.
  - step in IDLE is ignored, including a step in the same cycle as an accepted load. The first bit is always presented for at least one full cycle.
- SHIFT: bit_out holds the current bit while step=0.
  - step=1, counter>1: next bit appears after that edge; counter decrements.
  - step=1, counter=1 (last bit), repeat_en=1: reload from saved copy; bit_out=first bit again after the edge; bit_valid stays 1 with no gap.
  - step=1, counter=1, repeat_en=0: go to DONE; bit_valid=0, bit_out=0 after the edge.
  - load is ignored in SHIFT (ready=0); err is not raised.
- DONE: done=1 for exactly one cycle; ready=0; next state IDLE (ready=1 the following cycle).
- abort=1 in any state: next state IDLE; bit_valid=0, bit_out=0, ready=1; no done pulse. Overrides step and load in the same cycle.
- Latency: load accepted at edge k gives the first bit valid after edge k. Each step edge presents the next bit after that edge. For a single-shot pattern, done is high in the cycle after the last-bit step edge.
- Width: counter is LEN_W bits and never wraps below 1 in SHIFT. Bits above len-1 in data_in are don't-care.

Test Plan:
1. Hold rst=0 while toggling inputs -> bit_out=0, bit_valid=0, ready=1, done=0, err=0. Assert rst=0 asynchronously mid-SHIFT -> outputs return to reset values before the next clock edge.
2. load, data_in=8'h0C, len=4, step=1 every cycle, repeat_en=0 -> bit_out 1,1,0,0 on four consecutive cycles with bit_valid=1, then done=1 for one cycle, then ready=1. A Moore 1100 detector fed from bit_out flags detection.
3. Same load with step high one cycle in three -> each bit held 3 cycles; sequence still 1,1,0,0; single done pulse.
4. load, data_in=8'h0D, len=4, repeat_en=1, step every cycle -> 1101 1101 with no bit_valid gap. Drop repeat_en mid second pass -> that pass completes, then done. A Mealy 1101 detector pulses once per pass.
5. load with len=0, then with len=9 -> err pulses one cycle each, ready stays 1, bit_valid 0. load during SHIFT -> ignored, pattern unchanged.
6. abort asserted at the 2nd bit with step=1 the same cycle -> IDLE next cycle, bit_valid=0, no done. A new load immediately afterwards is accepted normally.
